fexpand: RTL and testbench

Input-side format expander for the FPU datapath. Takes a packed IEEE-754 operand (EW2-bit exponent, FW2-bit fraction) and produces the unpacked, normalized internal operand that the FPU arithmetic units consume: wide exponent, significand with explicit hidden bit and guard/round/sticky headroom, and class flags. It is the inverse of the normalize/round/pack stage at the end of the FPU pipe. It is a 2-stage valid/ready pipeline. Subnormals are pre-normalized, so every finite nonzero output has significandR[FW1] = 1.

---
 rtl/fexpand.sv | 188 ++++++++++++++++++
 tb/tb_fexpand.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fexpand.sv
// Input-side format expander: unpacks an IEEE-754 operand into the FPU's internal
// normalized form (wide exponent, explicit hidden bit, GRS headroom, class flags).
module fexpand #(
  parameter int FW1 = 26,
  parameter int FW2 = 23,
  parameter int EW1 = 10,
  parameter int EW2 = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [EW2+FW2:0]   operand_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [EW1-1:0]     exponentR,
  output logic [FW1:0]       significantR,
  output logic               signR,
  output logic               infR,
  output logic               nanR,
  output logic               zeroR,
  output logic               snanR
);

  localparam int LZW = $clog2(FW2);

  logic           inSign;
  logic [EW2-1:0] inExp;
  logic [FW2-1:0] inFrac;
  logic           expOnes, expZero, fracZero;
  logic [LZW-1:0] inLzc;

  logic           s1Valid_q, s1Valid_d;
  logic           s1Sign_q, s1Sign_d;
  logic [EW2-1:0] s1Exp_q, s1Exp_d;
  logic [FW2-1:0] s1Frac_q, s1Frac_d;
  logic           s1Inf_q, s1Inf_d;
  logic           s1Nan_q, s1Nan_d;
  logic           s1Snan_q, s1Snan_d;
  logic           s1Zero_q, s1Zero_d;
  logic           s1Sub_q, s1Sub_d;
  logic [LZW-1:0] s1Lzc_q, s1Lzc_d;

  logic           s2Valid_q, s2Valid_d;
  logic [EW1-1:0] s2Exp_q, s2Exp_d;
  logic [FW1:0]   s2Sig_q, s2Sig_d;
  logic           s2Sign_q, s2Sign_d;
  logic           s2Inf_q, s2Inf_d;
  logic           s2Nan_q, s2Nan_d;
  logic           s2Snan_q, s2Snan_d;
  logic           s2Zero_q, s2Zero_d;

  logic           s2Move, accept;
  logic [LZW:0]   shAmt;
  logic [FW1:0]   sigBase;

  assign inSign   = operand_i[EW2+FW2];
  assign inExp    = operand_i[EW2+FW2-1:FW2];
  assign inFrac   = operand_i[FW2-1:0];
  assign expOnes  = &inExp;
  assign expZero  = ~|inExp;
  assign fracZero = ~|inFrac;

  // Highest set bit wins, so iterating upward leaves the true leading-zero count.
  always_comb begin
    inLzc = '0;
    for (int i = 0; i < FW2; i++) begin
      if (inFrac[i]) inLzc = LZW'(FW2 - 1 - i);
    end
  end

  assign s2Move  = s1Valid_q && (!s2Valid_q || ready_i);
  assign ready_o = !s1Valid_q || s2Move;
  assign accept  = valid_i && ready_o;

  assign sigBase = {1'b0, s1Frac_q, {(FW1-FW2){1'b0}}};
  assign shAmt   = {1'b0, s1Lzc_q} + (LZW+1)'(1);

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Sign_d  = s1Sign_q;
    s1Exp_d   = s1Exp_q;
    s1Frac_d  = s1Frac_q;
    s1Inf_d   = s1Inf_q;
    s1Nan_d   = s1Nan_q;
    s1Snan_d  = s1Snan_q;
    s1Zero_d  = s1Zero_q;
    s1Sub_d   = s1Sub_q;
    s1Lzc_d   = s1Lzc_q;
    if (accept) begin
      s1Valid_d = 1'b1;
      s1Sign_d  = inSign;
      s1Exp_d   = inExp;
      s1Frac_d  = inFrac;
      s1Inf_d   = expOnes && fracZero;
      s1Nan_d   = expOnes && !fracZero;
      s1Snan_d  = expOnes && !fracZero && !inFrac[FW2-1];
      s1Zero_d  = expZero && fracZero;
      s1Sub_d   = expZero && !fracZero;
      s1Lzc_d   = inLzc;
    end else if (s2Move) begin
      s1Valid_d = 1'b0;
    end
  end

  // Inf/NaN fall through the normal path: the all-ones exponent and hidden bit are already right.
  always_comb begin
    s2Valid_d = s2Valid_q;
    s2Exp_d   = s2Exp_q;
    s2Sig_d   = s2Sig_q;
    s2Sign_d  = s2Sign_q;
    s2Inf_d   = s2Inf_q;
    s2Nan_d   = s2Nan_q;
    s2Snan_d  = s2Snan_q;
    s2Zero_d  = s2Zero_q;
    if (s2Move) begin
      s2Valid_d = 1'b1;
      s2Sign_d  = s1Sign_q;
      s2Inf_d   = s1Inf_q;
      s2Nan_d   = s1Nan_q;
      s2Snan_d  = s1Snan_q;
      s2Zero_d  = s1Zero_q;
      s2Exp_d   = {{(EW1-EW2){1'b0}}, s1Exp_q};
      s2Sig_d   = {1'b1, s1Frac_q, {(FW1-FW2){1'b0}}};
      if (s1Zero_q) begin
        s2Exp_d = '0;
        s2Sig_d = '0;
      end else if (s1Sub_q) begin
        s2Exp_d = -{{(EW1-LZW){1'b0}}, s1Lzc_q};
        s2Sig_d = sigBase << shAmt;
      end
    end else if (ready_i) begin
      s2Valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Exp_q   <= '0;
      s1Frac_q  <= '0;
      s1Inf_q   <= 1'b0;
      s1Nan_q   <= 1'b0;
      s1Snan_q  <= 1'b0;
      s1Zero_q  <= 1'b0;
      s1Sub_q   <= 1'b0;
      s1Lzc_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Exp_q   <= '0;
      s2Sig_q   <= '0;
      s2Sign_q  <= 1'b0;
      s2Inf_q   <= 1'b0;
      s2Nan_q   <= 1'b0;
      s2Snan_q  <= 1'b0;
      s2Zero_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Sign_q  <= s1Sign_d;
      s1Exp_q   <= s1Exp_d;
      s1Frac_q  <= s1Frac_d;
      s1Inf_q   <= s1Inf_d;
      s1Nan_q   <= s1Nan_d;
      s1Snan_q  <= s1Snan_d;
      s1Zero_q  <= s1Zero_d;
      s1Sub_q   <= s1Sub_d;
      s1Lzc_q   <= s1Lzc_d;
      s2Valid_q <= s2Valid_d;
      s2Exp_q   <= s2Exp_d;
      s2Sig_q   <= s2Sig_d;
      s2Sign_q  <= s2Sign_d;
      s2Inf_q   <= s2Inf_d;
      s2Nan_q   <= s2Nan_d;
      s2Snan_q  <= s2Snan_d;
      s2Zero_q  <= s2Zero_d;
    end
  end

  assign valid_o      = s2Valid_q;
  assign exponentR    = s2Exp_q;
  assign significantR = s2Sig_q;
  assign signR        = s2Sign_q;
  assign infR         = s2Inf_q;
  assign nanR         = s2Nan_q;
  assign zeroR        = s2Zero_q;
  assign snanR        = s2Snan_q;

endmodule

// File: tb/tb_fexpand.sv
// Scoreboard bench for fexpand: expected results are queued on input transfer
// and compared when the DUT presents (and while it holds) each output.
module tb_fexpand;

  typedef struct {
    logic [9:0]  ex;
    logic [26:0] sig;
    logic [4:0]  flags;   // {sign, inf, nan, zero, snan}
    int          cyc;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_i;
  logic        valid_o;
  logic        ready_i;
  logic [9:0]  exponentR;
  logic [26:0] significantR;
  logic        signR, infR, nanR, zeroR, snanR;

  int      testsRun = 0;
  int      testsFailed = 0;
  int      cycleCnt = 0;
  bit      monitorOn = 1'b0;
  bit      checkLat = 1'b0;
  expect_t sb[$];
  expect_t monE;

  fexpand dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .operand_i(operand_i), .valid_o(valid_o), .ready_i(ready_i),
    .exponentR(exponentR), .significantR(significantR),
    .signR(signR), .infR(infR), .nanR(nanR), .zeroR(zeroR), .snanR(snanR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleCnt);
    end
  endtask

  // Reference: subnormals are normalized by shifting until the hidden bit is set.
  function automatic expect_t refModel(input logic [31:0] op);
    expect_t     e;
    logic [7:0]  ex8;
    logic [22:0] fr;
    int          ex;
    ex8 = op[30:23];
    fr  = op[22:0];
    e.cyc = 0;
    e.flags = {op[31], 4'b0000};
    if (ex8 == 8'hFF) begin
      e.ex  = 10'h0FF;
      e.sig = {1'b1, fr, 3'b000};
      if (fr == 0) e.flags[3] = 1'b1;
      else begin
        e.flags[2] = 1'b1;
        e.flags[0] = !fr[22];
      end
    end else if (ex8 == 0 && fr == 0) begin
      e.ex  = '0;
      e.sig = '0;
      e.flags[1] = 1'b1;
    end else if (ex8 == 0) begin
      e.sig = {1'b0, fr, 3'b000};
      ex = 1;
      while (!e.sig[26]) begin
        e.sig = e.sig << 1;
        ex = ex - 1;
      end
      e.ex = ex[9:0];
    end else begin
      e.ex  = {2'b00, ex8};
      e.sig = {1'b1, fr, 3'b000};
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] op, input expect_t e);
    bit done = 1'b0;
    operand_i = op;
    valid_i = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (ready_o) begin
        e.cyc = cycleCnt;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("acceptTimeout", 32'd0, 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic applyKnown(input logic [31:0] op, input logic [9:0] ex, input logic [26:0] sig, input logic [4:0] fl);
    expect_t e;
    e.ex = ex; e.sig = sig; e.flags = fl; e.cyc = 0;
    applyStimulus(op, e);
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput("drained", sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (monitorOn && !rst && valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousOutput", 32'd1, 32'd0);
      end else begin
        monE = sb[0];
        checkOutput("exponentR", exponentR, monE.ex);
        checkOutput("significantR", significantR, monE.sig);
        checkOutput("flags", {signR, infR, nanR, zeroR, snanR}, monE.flags);
        if (ready_i) begin
          if (checkLat) checkOutput("latency", cycleCnt - monE.cyc, 32'd2);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] op;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; operand_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetValid", valid_o, 32'd0);
    checkOutput("resetReady", ready_o, 32'd1);
    checkOutput("resetExp", exponentR, 32'd0);
    checkOutput("resetSig", significantR, 32'd0);
    checkOutput("resetFlags", {signR, infR, nanR, zeroR, snanR}, 32'd0);
    monitorOn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-derived results
    checkLat = 1'b1;
    applyKnown(32'h3F800000, 10'h07F, 27'h4000000, 5'b00000);
    @(posedge clk); #1;
    applyKnown(32'h00000001, 10'h3EA, 27'h4000000, 5'b00000);
    applyKnown(32'h007FFFFF, 10'h000, 27'h7FFFFF0, 5'b00000);
    applyKnown(32'h80000000, 10'h000, 27'h0000000, 5'b10010);
    applyKnown(32'hFF800000, 10'h0FF, 27'h4000000, 5'b11000);
    applyKnown(32'h7FC00000, 10'h0FF, 27'h6000000, 5'b00100);
    applyKnown(32'h7F800001, 10'h0FF, 27'h4000008, 5'b00101);
    waitDrain();

    // Full throughput: 8 back-to-back operands, ready_i held high
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      op = $urandom;
      if (i % 3 == 0) op[30:23] = 8'h00;
      if (i == 4) op[30:23] = 8'hFF;
      applyStimulus(op, refModel(op));
    end
    waitDrain();

    // Backpressure: ready_i low for four cycles while streaming
    checkLat = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          op = $urandom;
          if (i == 2) op[30:23] = 8'h00;
          applyStimulus(op, refModel(op));
        end
      end
      begin
        @(posedge clk); #1 ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("readyStallFull", ready_o, 32'd0);
        @(negedge clk);
        checkOutput("readyStallHeld", ready_o, 32'd0);
        @(posedge clk); @(posedge clk); #1 ready_i = 1'b1;
      end
    join
    waitDrain();

    // Reset with both stages occupied
    @(posedge clk); #1;
    ready_i = 1'b0;
    op = 32'h40490FDB; applyStimulus(op, refModel(op));
    op = 32'h00000010; applyStimulus(op, refModel(op));
    @(negedge clk);
    checkOutput("preResetValid", valid_o, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; valid_i = 1'b1; operand_i = 32'h3F800000;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    checkOutput("midResetValid", valid_o, 32'd0);
    checkOutput("midResetReady", ready_o, 32'd1);
    checkOutput("midResetExp", exponentR, 32'd0);
    checkOutput("midResetSig", significantR, 32'd0);
    checkOutput("midResetFlags", {signR, infR, nanR, zeroR, snanR}, 32'd0);
    @(posedge clk); #1 ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkLat = 1'b1;
    op = 32'hC2F60000; applyStimulus(op, refModel(op));
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
